// File: rtl/ifm_bank_loader_if.sv
// IFM word stream and bias word stream between a DMA/host source and the bank loader.
// The source drives valid/data/last; the loader returns the ready signals.
interface ifm_bank_loader_if #(
  parameter int DATA_W = 128,
  parameter int BIAS_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              b_valid;
  logic              b_ready;
  logic [BIAS_W-1:0] b_data;

  modport master (
    output s_valid, s_data, s_last, b_valid, b_data,
    input  s_ready, b_ready
  );

  modport slave (
    input  s_valid, s_data, s_last, b_valid, b_data,
    output s_ready, b_ready
  );
endinterface

// File: rtl/ifm_bank_loader.sv
// Fills a banked IFM BRAM from a word stream, latches per-channel biases, then pulses layer start.
// Optional cycle counter output o_cycles is built only when IFM_LOADER_PERF_CNT_EN is defined.
module ifm_bank_loader #(
  parameter int DATA_W     = 128,
  parameter int NUM_BANKS  = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 9,
  parameter int NUM_CH     = 4,
  parameter int BIAS_W     = 16,
  parameter int INTERLEAVE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  ifm_bank_loader_if.slave         s_if,
  output logic [NUM_BANKS-1:0]     o_ena,
  output logic [NUM_BANKS-1:0]     o_wea,
  output logic [ADDR_W-1:0]        o_addra,
  output logic [DATA_W-1:0]        o_dia,
  output logic [NUM_CH*BIAS_W-1:0] o_bias,
  output logic                     o_layer_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
`ifdef IFM_LOADER_PERF_CNT_EN
  ,
  output logic [31:0]              o_cycles
`endif
);

  localparam int TOTAL = NUM_BANKS * DEPTH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int BI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_IFM,
    ST_LOAD_BIAS,
    ST_START,
    ST_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_BANKS-1:0] r_bank;
  logic [ADDR_W-1:0]    r_addr;
  logic [CNT_W-1:0]     r_word_cnt;
  logic [BI_W-1:0]      r_bias_idx;
  logic [NUM_BANKS-1:0] r_ena;
  logic [ADDR_W-1:0]    r_addra;
  logic [DATA_W-1:0]    r_dia;
  logic                 r_err;

  logic                 w_in_ifm;
  logic                 w_in_bias;
  logic                 w_s_hs;
  logic                 w_b_hs;
  logic                 w_start_acc;
  logic                 w_last_word;
  logic                 w_ifm_end;
  logic                 w_bias_end;
  logic [NUM_BANKS-1:0] w_bank_rot;
  logic [NUM_BANKS-1:0] w_bank_next;
  logic [ADDR_W-1:0]    w_addr_next;

  assign w_in_ifm    = (r_state == ST_LOAD_IFM);
  assign w_in_bias   = (r_state == ST_LOAD_BIAS);
  assign w_s_hs      = s_if.s_valid & w_in_ifm;
  assign w_b_hs      = s_if.b_valid & w_in_bias;
  assign w_start_acc = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last_word = (r_word_cnt == CNT_W'(TOTAL - 1));
  // An early s_last ends the fill just like the final word does.
  assign w_ifm_end   = w_s_hs & (w_last_word | s_if.s_last);
  assign w_bias_end  = w_b_hs & (r_bias_idx == BI_W'(NUM_CH - 1));

  generate
    if (NUM_BANKS == 1) begin : g_rot_single
      assign w_bank_rot = r_bank;
    end else begin : g_rot_multi
      assign w_bank_rot = {r_bank[NUM_BANKS-2:0], r_bank[NUM_BANKS-1]};
    end

    if (INTERLEAVE != 0) begin : g_interleave
      assign w_bank_next = w_bank_rot;
      assign w_addr_next = r_bank[NUM_BANKS-1] ? r_addr + ADDR_W'(1) : r_addr;
    end else begin : g_bank_major
      logic w_addr_wrap;
      assign w_addr_wrap = (r_addr == ADDR_W'(DEPTH - 1));
      assign w_bank_next = w_addr_wrap ? w_bank_rot : r_bank;
      assign w_addr_next = w_addr_wrap ? '0 : r_addr + ADDR_W'(1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (i_start) w_state_next = ST_LOAD_IFM;
      ST_LOAD_IFM:  if (w_ifm_end) w_state_next = ST_LOAD_BIAS;
      ST_LOAD_BIAS: if (w_bias_end) w_state_next = ST_START;
      ST_START:     w_state_next = ST_DONE;
      ST_DONE:      if (i_start) w_state_next = ST_LOAD_IFM;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Write port is registered: an accepted word lands on the BRAM port one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank     <= '0;
      r_addr     <= '0;
      r_word_cnt <= '0;
      r_bias_idx <= '0;
      r_ena      <= '0;
      r_addra    <= '0;
      r_dia      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ena <= '0;
      if (w_start_acc) begin
        r_bank     <= NUM_BANKS'(1);
        r_addr     <= '0;
        r_word_cnt <= '0;
        r_bias_idx <= '0;
        r_err      <= 1'b0;
      end
      if (w_s_hs) begin
        r_ena      <= r_bank;
        r_addra    <= r_addr;
        r_dia      <= s_if.s_data;
        r_bank     <= w_bank_next;
        r_addr     <= w_addr_next;
        r_word_cnt <= r_word_cnt + CNT_W'(1);
        if (s_if.s_last != w_last_word) begin
          r_err <= 1'b1;
        end
      end
      if (w_b_hs) begin
        r_bias_idx <= r_bias_idx + BI_W'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bias
      logic [BIAS_W-1:0] r_bias_ch;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_bias_ch <= '0;
        end else if (w_b_hs && (r_bias_idx == BI_W'(gi))) begin
          r_bias_ch <= s_if.b_data;
        end
      end
      assign o_bias[gi*BIAS_W +: BIAS_W] = r_bias_ch;
    end
  endgenerate

`ifdef IFM_LOADER_PERF_CNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= '0;
    end else if (w_start_acc) begin
      r_cycles <= '0;
    end else if (o_busy && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign o_cycles = r_cycles;
`endif

  assign s_if.s_ready  = w_in_ifm;
  assign s_if.b_ready  = w_in_bias;
  assign o_ena         = r_ena;
  assign o_wea         = r_ena;
  assign o_addra       = r_addra;
  assign o_dia         = r_dia;
  assign o_layer_start = (r_state == ST_START);
  assign o_busy        = w_in_ifm | w_in_bias | (r_state == ST_START);
  assign o_done        = (r_state == ST_DONE);
  assign o_err         = r_err;

endmodule

// File: tb/tb_ifm_bank_loader.sv
// Directed bench: a 16x128 bank-major loader and a 4x4 interleaved loader sharing one stimulus source.
module tb_ifm_bank_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Shared stimulus, steered to loader A (sel=0) or loader B (sel=1).
  logic        sel = 1'b0;
  logic        st  = 1'b0;
  logic        v   = 1'b0;
  logic        l   = 1'b0;
  logic        bv  = 1'b0;
  logic [31:0] d   = '0;
  logic [15:0] bd  = '0;

  ifm_bank_loader_if #(.DATA_W(32), .BIAS_W(16)) sif_a ();
  ifm_bank_loader_if #(.DATA_W(32), .BIAS_W(16)) sif_b ();

  assign sif_a.s_valid = v & ~sel;
  assign sif_a.s_data  = d;
  assign sif_a.s_last  = l & ~sel;
  assign sif_a.b_valid = bv & ~sel;
  assign sif_a.b_data  = bd;
  assign sif_b.s_valid = v & sel;
  assign sif_b.s_data  = d;
  assign sif_b.s_last  = l & sel;
  assign sif_b.b_valid = bv & sel;
  assign sif_b.b_data  = bd;

  logic        start_a, start_b;
  logic [15:0] ena_a, wea_a;
  logic [8:0]  addra_a;
  logic [31:0] dia_a;
  logic [63:0] bias_a;
  logic        ls_a, busy_a, done_a, err_a;
  logic [3:0]  ena_b, wea_b;
  logic [2:0]  addra_b;
  logic [31:0] dia_b;
  logic [63:0] bias_b;
  logic        ls_b, busy_b, done_b, err_b;
`ifdef IFM_LOADER_PERF_CNT_EN
  logic [31:0] cyc_a, cyc_b;
`endif

  assign start_a = st & ~sel;
  assign start_b = st & sel;

  ifm_bank_loader #(
    .DATA_W(32), .NUM_BANKS(16), .DEPTH(128), .ADDR_W(9),
    .NUM_CH(4), .BIAS_W(16), .INTERLEAVE(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .s_if(sif_a),
    .o_ena(ena_a), .o_wea(wea_a), .o_addra(addra_a), .o_dia(dia_a),
    .o_bias(bias_a), .o_layer_start(ls_a), .o_busy(busy_a),
    .o_done(done_a), .o_err(err_a)
`ifdef IFM_LOADER_PERF_CNT_EN
    , .o_cycles(cyc_a)
`endif
  );

  ifm_bank_loader #(
    .DATA_W(32), .NUM_BANKS(4), .DEPTH(4), .ADDR_W(3),
    .NUM_CH(4), .BIAS_W(16), .INTERLEAVE(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .s_if(sif_b),
    .o_ena(ena_b), .o_wea(wea_b), .o_addra(addra_b), .o_dia(dia_b),
    .o_bias(bias_b), .o_layer_start(ls_b), .o_busy(busy_b),
    .o_done(done_b), .o_err(err_b)
`ifdef IFM_LOADER_PERF_CNT_EN
    , .o_cycles(cyc_b)
`endif
  );

  logic w_ready, w_bready, w_done;
  assign w_ready  = sel ? sif_b.s_ready : sif_a.s_ready;
  assign w_bready = sel ? sif_b.b_ready : sif_a.b_ready;
  assign w_done   = sel ? done_b : done_a;

  // BRAM models fed by the write ports, sampled mid-cycle.
  logic [31:0] mem_a [0:15][0:127];
  logic [31:0] mem_b [0:3][0:3];
  int wr_cnt_a = 0, wr_bad_a = 0, ls_cnt_a = 0, wr_at_ls_a = 0;
  int wr_cnt_b = 0, wr_bad_b = 0, ls_cnt_b = 0, wr_at_ls_b = 0;
  int wr_addr_b [0:63];

  always @(negedge clk) begin
    if (ena_a != '0) begin
      if (!$onehot(ena_a) || (wea_a != ena_a) || (addra_a > 9'd127)) wr_bad_a++;
      else mem_a[$clog2(ena_a)][addra_a[6:0]] = dia_a;
      wr_cnt_a++;
    end else if (wea_a != '0) begin
      wr_bad_a++;
    end
    if (ls_a) begin
      ls_cnt_a++;
      wr_at_ls_a = wr_cnt_a;
    end
  end

  always @(negedge clk) begin
    if (ena_b != '0) begin
      if (!$onehot(ena_b) || (wea_b != ena_b) || (addra_b > 3'd3)) wr_bad_b++;
      else mem_b[$clog2(ena_b)][addra_b[1:0]] = dia_b;
      wr_addr_b[wr_cnt_b % 64] = int'(addra_b);
      wr_cnt_b++;
    end else if (wea_b != '0) begin
      wr_bad_b++;
    end
    if (ls_b) begin
      ls_cnt_b++;
      wr_at_ls_b = wr_cnt_b;
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic pulse_start();
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
  endtask

  task automatic send_words(input int n, input int base, input int last_pos,
                            input bit gap, input bit glitch, output int cyc);
    int i;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 5000) begin
      v  = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
      d  = 32'(base + i);
      l  = (i == last_pos);
      st = glitch && (i % 4 == 2);
      @(negedge clk);
      if (v && w_ready) i++;
      cyc++;
      @(posedge clk); #1;
    end
    v = 1'b0; l = 1'b0; st = 1'b0;
    total++;
    if (i != n) begin
      bad++;
      $display("FAIL words_accepted: got %0d want %0d", i, n);
    end
  endtask

  task automatic send_bias(input logic [15:0] base);
    int j, cyc;
    j = 0;
    cyc = 0;
    while (j < 4 && cyc < 100) begin
      bv = 1'b1;
      bd = base + 16'(j);
      @(negedge clk);
      if (w_bready) j++;
      cyc++;
      @(posedge clk); #1;
    end
    bv = 1'b0;
    total++;
    if (j != 4) begin
      bad++;
      $display("FAIL bias_accepted: got %0d want 4", j);
    end
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!w_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!w_done) begin
      bad++;
      $display("FAIL done_timeout: o_done=%0b want 1", w_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({ena_a, wea_a, addra_a, dia_a, bias_a} !== '0) begin
      bad++;
      $display("FAIL reset_a_port: ena=%h addr=%h dia=%h bias=%h want 0", ena_a, addra_a, dia_a, bias_a);
    end
    total++;
    if ({ls_a, busy_a, done_a, err_a, sif_a.s_ready, sif_a.b_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_a_ctrl: ls/busy/done/err/sr/br=%b want 000000",
               {ls_a, busy_a, done_a, err_a, sif_a.s_ready, sif_a.b_ready});
    end
    total++;
    if ({ena_b, wea_b, addra_b, dia_b, bias_b, ls_b, busy_b, done_b, err_b, sif_b.s_ready, sif_b.b_ready} !== '0) begin
      bad++;
      $display("FAIL reset_b: ena=%h addr=%h dia=%h bias=%h ctrl=%b want 0", ena_b, addra_b, dia_b, bias_b,
               {ls_b, busy_b, done_b, err_b, sif_b.s_ready, sif_b.b_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bank_major();
    int w0, l0, cyc, errs;
    sel = 1'b0;
    w0 = wr_cnt_a;
    l0 = ls_cnt_a;
    pulse_start();
    send_words(2048, 0, 2047, 1'b0, 1'b0, cyc);
    total++;
    if (cyc != 2048) begin
      bad++;
      $display("FAIL bm_b2b_cycles: got %0d want 2048", cyc);
    end
    send_bias(16'hB000);
    wait_done();
    errs = 0;
    for (int k = 0; k < 16; k++)
      for (int a = 0; a < 128; a++)
        if (mem_a[k][a] !== 32'(k * 128 + a)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bm_image: %0d words wrong, bank15 addr127=%h want %h", errs, mem_a[15][127], 32'd2047);
    end
    total++;
    if (wr_cnt_a - w0 != 2048 || wr_bad_a != 0) begin
      bad++;
      $display("FAIL bm_writes: count=%0d bad=%0d want 2048/0", wr_cnt_a - w0, wr_bad_a);
    end
    total++;
    if (ls_cnt_a - l0 != 1 || wr_at_ls_a != w0 + 2048) begin
      bad++;
      $display("FAIL bm_layer_start: pulses=%0d writes_before=%0d want 1/%0d", ls_cnt_a - l0, wr_at_ls_a - w0, 2048);
    end
    total++;
    if (err_a !== 1'b0) begin
      bad++;
      $display("FAIL bm_err: got %b want 0", err_a);
    end
    total++;
    if (bias_a !== 64'hB003_B002_B001_B000) begin
      bad++;
      $display("FAIL bm_bias: got %h want b003b002b001b000", bias_a);
    end
`ifdef IFM_LOADER_PERF_CNT_EN
    total++;
    if (cyc_a !== 32'd2053) begin
      bad++;
      $display("FAIL bm_cycles: got %0d want 2053", cyc_a);
    end
`endif
  endtask

  task automatic test_interleave();
    int w0, l0, cyc, errs, aerrs;
    sel = 1'b1;
    w0 = wr_cnt_b;
    l0 = ls_cnt_b;
    pulse_start();
    send_words(16, 0, 15, 1'b0, 1'b0, cyc);
    send_bias(16'hA000);
    wait_done();
    errs = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++)
        if (mem_b[b][a] !== 32'(4 * a + b)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL il_image: %0d words wrong, bank1 addr2=%h want 9", errs, mem_b[1][2]);
    end
    aerrs = 0;
    for (int i = 0; i < 16; i++)
      if (wr_addr_b[(w0 + i) % 64] != i / 4) aerrs++;
    total++;
    if (aerrs != 0 || wr_cnt_b - w0 != 16) begin
      bad++;
      $display("FAIL il_addr_seq: %0d wrong addrs, writes=%0d want 0/16", aerrs, wr_cnt_b - w0);
    end
    total++;
    if (ls_cnt_b - l0 != 1 || wr_at_ls_b != w0 + 16 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL il_finish: pulses=%0d writes_before=%0d err=%b want 1/16/0", ls_cnt_b - l0, wr_at_ls_b - w0, err_b);
    end
    total++;
    if (bias_b !== 64'hA003_A002_A001_A000) begin
      bad++;
      $display("FAIL il_bias: got %h want a003a002a001a000", bias_b);
    end
`ifdef IFM_LOADER_PERF_CNT_EN
    total++;
    if (cyc_b !== 32'd21) begin
      bad++;
      $display("FAIL il_cycles: got %0d want 21", cyc_b);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cyc_b !== 32'd21) begin
      bad++;
      $display("FAIL il_cycles_hold: got %0d want 21", cyc_b);
    end
`endif
  endtask

  task automatic test_gaps();
    int w0, cyc, errs;
    sel = 1'b1;
    w0 = wr_cnt_b;
    pulse_start();
    send_words(16, 100, 15, 1'b1, 1'b0, cyc);
    send_bias(16'h9000);
    wait_done();
    errs = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++)
        if (mem_b[b][a] !== 32'(100 + 4 * a + b)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL gap_image: %0d words wrong, bank3 addr3=%h want %h", errs, mem_b[3][3], 32'd115);
    end
    total++;
    if (wr_cnt_b - w0 != 16 || wr_bad_b != 0) begin
      bad++;
      $display("FAIL gap_writes: count=%0d bad=%0d want 16/0", wr_cnt_b - w0, wr_bad_b);
    end
  endtask

  task automatic test_early_last();
    int cyc;
    sel = 1'b1;
    pulse_start();
    send_words(10, 50, 9, 1'b0, 1'b0, cyc);
    total++;
    if (err_b !== 1'b1) begin
      bad++;
      $display("FAIL el_err_set: got %b want 1", err_b);
    end
    total++;
    if ({sif_b.s_ready, sif_b.b_ready} !== 2'b01) begin
      bad++;
      $display("FAIL el_to_bias: s_ready/b_ready=%b want 01", {sif_b.s_ready, sif_b.b_ready});
    end
    send_bias(16'h5000);
    wait_done();
    total++;
    if (err_b !== 1'b1) begin
      bad++;
      $display("FAIL el_err_sticky: got %b want 1", err_b);
    end
    pulse_start();
    total++;
    if (err_b !== 1'b0) begin
      bad++;
      $display("FAIL el_err_clear: got %b want 0", err_b);
    end
    send_words(16, 300, -1, 1'b0, 1'b0, cyc);
    send_bias(16'h6000);
    wait_done();
    total++;
    if (err_b !== 1'b1) begin
      bad++;
      $display("FAIL el_missing_last: got %b want 1", err_b);
    end
  endtask

  task automatic test_rst_mid();
    int w0, l0, cyc, errs;
    sel = 1'b1;
    pulse_start();
    send_words(4, 0, -1, 1'b0, 1'b0, cyc);
    v = 1'b1; d = 32'd4; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; v = 1'b0;
    @(negedge clk);
    total++;
    if ({ena_b, wea_b, addra_b, dia_b, bias_b, ls_b, busy_b, done_b, err_b, sif_b.s_ready} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: ena=%h addr=%h dia=%h bias=%h busy=%b err=%b want 0",
               ena_b, addra_b, dia_b, bias_b, busy_b, err_b);
    end
    @(posedge clk); #1;
    w0 = wr_cnt_b;
    l0 = ls_cnt_b;
    pulse_start();
    send_words(16, 200, 15, 1'b0, 1'b1, cyc);
    send_bias(16'hC000);
    wait_done();
    errs = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++)
        if (mem_b[b][a] !== 32'(200 + 4 * a + b)) errs++;
    total++;
    if (errs != 0 || wr_cnt_b - w0 != 16) begin
      bad++;
      $display("FAIL rst_reload_image: %0d words wrong, writes=%0d want 0/16", errs, wr_cnt_b - w0);
    end
    total++;
    if (ls_cnt_b - l0 != 1 || bias_b !== 64'hC003_C002_C001_C000 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL rst_reload_finish: pulses=%0d bias=%h err=%b want 1/c003c002c001c000/0",
               ls_cnt_b - l0, bias_b, err_b);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_bank_major();
    test_interleave();
    test_gaps();
    test_early_last();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifm_bank_loader.md
Name: ifm_bank_loader

Overview:
Parametrised loader that fills a layer's banked input-feature-map BRAM from a valid/ready word stream, then latches per-channel biases and fires the layer start pulse. It generalises the fixed 16-bank × 128-entry, one-hot write scheme to any bank count, depth and word width, and adds an interleaved fill mode. It sits between the DMA/host stream and a convolution layer's BRAM write port (ena/wea/addra/dia), bias inputs and iStart.

Parameters:
DATA_W, 128, IFM word width (BRAM write data).
NUM_BANKS, 16, number of BRAM banks; one-hot enable width.
DEPTH, 128, words per bank.
ADDR_W, 9, BRAM address width; DEPTH <= 2**ADDR_W.
NUM_CH, 4, bias channels.
BIAS_W, 16, bias word width.
INTERLEAVE, 0, 0 = bank-major fill (bank 0 addr 0..DEPTH-1, then bank 1, ...); 1 = round-robin (addr 0 of banks 0..NUM_BANKS-1, then addr 1, ...).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  begin a load sequence (sampled in IDLE/DONE only)
s_valid  in  1  IFM stream word valid
s_ready  out  1  IFM stream ready
s_data  in  DATA_W  IFM stream word
s_last  in  1  marks final IFM word
b_valid  in  1  bias word valid
b_ready  out  1  bias ready
b_data  in  BIAS_W  bias word, channel order 0..NUM_CH-1
o_ena  out  NUM_BANKS  one-hot bank enable
o_wea  out  NUM_BANKS  one-hot bank write enable (== o_ena)
o_addra  out  ADDR_W  write address
o_dia  out  DATA_W  write data
o_bias  out  NUM_CH*BIAS_W  latched biases, ch0 in LSBs
o_layer_start  out  1  one-cycle start pulse to layer
o_busy  out  1  high in LOAD_IFM/LOAD_BIAS/START
o_done  out  1  high in DONE
o_err  out  1  sticky: s_last position mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, o_bias 0.
- FSM: IDLE -> LOAD_IFM on i_start; LOAD_IFM -> LOAD_BIAS after NUM_BANKS*DEPTH words accepted or early s_last; LOAD_BIAS -> START after NUM_CH bias handshakes; START -> DONE (1 cycle); DONE -> LOAD_IFM on i_start.
- i_start ignored while o_busy.
- s_ready = 1 only in LOAD_IFM. Handshake = s_valid & s_ready.
- Write port is registered: a handshake in cycle N drives o_ena/o_wea one-hot, o_addra, o_dia in cycle N+1; otherwise o_ena/o_wea = 0 and o_addra/o_dia hold.
- Bank-major mode: addr increments per word; on addr = DEPTH-1 it wraps to 0 and bank advances (one-hot shift left).
- Interleave mode: bank advances per word; on bank = NUM_BANKS-1 it wraps to bank 0 and addr increments.
- o_err set when s_last arrives before the final word, or the final word arrives without s_last. Early s_last still ends LOAD_IFM. Cleared only by rst or the next i_start.
- b_ready = 1 only in LOAD_BIAS. Bias k is written into slice k on handshake, k = 0..NUM_CH-1. Biases are held until the next load's bias phase.
- o_layer_start is high exactly one cycle, in START, and o_bias is stable in that cycle. The last write reaches BRAM before this pulse.
- rst mid-load returns to IDLE immediately: the write-enable in that cycle is suppressed and partial data is abandoned.
- Back-to-back s_valid sustains one word per clock; bubbles are tolerated.

Optional Feature:
IFM_LOADER_PERF_CNT_EN. When defined, adds output o_cycles[31:0]: it clears on the accepted i_start, counts every clk until o_layer_start inclusive, then holds, saturating at 32'hFFFF_FFFF. When undefined, the port and counter are absent.

Test Plan:
- NUM_BANKS=16, DEPTH=128, bank-major, 2048 continuous words, 4 biases -> bank k addr a holds word k*128+a; o_ena walks 0x0001..0x8000; o_layer_start exactly once after last write; o_err=0.
- NUM_BANKS=4, DEPTH=4, INTERLEAVE=1, 16 words with value = index -> bank b addr a holds 4*a+b; o_addra changes every 4 writes.
- Random s_valid gaps, 50% duty -> same memory image as the gap-free run; no write while o_ena=0.
- s_last on word 10 of 16 (NUM_BANKS=4, DEPTH=4) -> o_err=1, FSM enters LOAD_BIAS, and o_err clears on the next i_start.
- rst asserted on word 5, then a full reload -> all outputs 0 the cycle after rst; reload image correct; i_start pulses during LOAD_IFM ignored.
- With IFM_LOADER_PERF_CNT_EN, gap-free 16-word and 4-bias load (NUM_BANKS=4, DEPTH=4) -> o_cycles holds a fixed value equal to the cycle count from i_start to o_layer_start inclusive, and stays constant in DONE.
